// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Purpose:
//   EX-stage execution unit for one superscalar lane. It combines ALUOp/funct
//   decode, a registered single-cycle ALU and an iterative multiply/divide
//   engine that writes the HI/LO register pair. Single-cycle ops return a
//   result one cycle after accept. MULT/DIV take DATA_W+2 cycles and hold
//   in_ready low while the engine is busy.
//
// Parameters:
//   DATA_W   - operand/result width (even, >= 8)
//   HILO_RST - value loaded into HI and LO on reset
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset
//   in_valid  in   operation presented this cycle
//   in_ready  out  unit can accept (only while idle)
//   alu_op    in   00 add, 01 sub, 10 R-type (funct), 11 slt
//   funct     in   R-type function field
//   src_a     in   operand A / dividend / multiplicand
//   src_b     in   operand B / divisor / multiplier
//   out_valid out  one-cycle result pulse
//   result    out  registered result (new LO for MULT/DIV)
//   zero      out  result == 0, qualified by out_valid
//   hi, lo    out  HI/LO registers
//   illegal   out  unknown funct, qualified by out_valid
//   ovf       out  signed add/sub overflow
//
// Build option:
//   ALU_OVF_TRAP_EN - when defined, ovf reports signed add/sub overflow.
//                     When undefined, ovf is tied low.
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] HILO_RST = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              illegal,
  output logic              ovf
);

  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   a_mag_q, a_mag_d;
  logic [DATA_W-1:0]   b_mag_q, b_mag_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic                is_div_q, is_div_d;
  logic                div_zero_q, div_zero_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                out_valid_q, out_valid_d;
  logic                illegal_q, illegal_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  logic [DATA_W-1:0]   add_res, sub_res, slt_res, sltu_res;
  logic [DATA_W-1:0]   sc_res;
  logic                sc_illegal;
  logic                is_muldiv, md_signed, md_div;
  logic [DATA_W-1:0]   a_mag_in, b_mag_in;

  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_step;
  logic [DATA_W:0]     div_shift, div_diff;
  logic [2*DATA_W-1:0] div_step;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix, a_orig;

  assign add_res  = src_a + src_b;
  assign sub_res  = src_a - src_b;
  assign slt_res  = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
  assign sltu_res = {{(DATA_W-1){1'b0}}, (src_a < src_b)};

  // Decode alu_op/funct into a single-cycle result, or flag a mult/div
  // request together with its signedness and kind.
  always_comb begin
    sc_res     = '0;
    sc_illegal = 1'b0;
    is_muldiv  = 1'b0;
    md_signed  = 1'b0;
    md_div     = 1'b0;
    case (alu_op)
      2'b00: sc_res = add_res;
      2'b01: sc_res = sub_res;
      2'b11: sc_res = slt_res;
      default: begin
        case (funct)
          F_ADD:   sc_res = add_res;
          F_SUB:   sc_res = sub_res;
          F_AND:   sc_res = src_a & src_b;
          F_OR:    sc_res = src_a | src_b;
          F_XOR:   sc_res = src_a ^ src_b;
          F_NOR:   sc_res = ~(src_a | src_b);
          F_SLT:   sc_res = slt_res;
          F_SLTU:  sc_res = sltu_res;
          F_MFHI:  sc_res = hi_q;
          F_MFLO:  sc_res = lo_q;
          F_MULT:  begin is_muldiv = 1'b1; md_signed = 1'b1; end
          F_MULTU: begin is_muldiv = 1'b1; end
          F_DIV:   begin is_muldiv = 1'b1; md_signed = 1'b1; md_div = 1'b1; end
          F_DIVU:  begin is_muldiv = 1'b1; md_div = 1'b1; end
          default: sc_illegal = 1'b1;
        endcase
      end
    endcase
  end

  // Signed variants run on magnitudes; the signs are reapplied in FIX.
  assign a_mag_in = (md_signed && src_a[DATA_W-1]) ? -src_a : src_a;
  assign b_mag_in = (md_signed && src_b[DATA_W-1]) ? -src_b : src_b;

  // Shift-add multiply: prod holds {accumulator, remaining multiplier bits}.
  assign mul_sum  = {1'b0, prod_q[2*DATA_W-1:DATA_W]} +
                    (prod_q[0] ? {1'b0, a_mag_q} : {(DATA_W+1){1'b0}});
  assign mul_step = {mul_sum, prod_q[DATA_W-1:1]};

  // Restoring divide: prod holds {partial remainder, dividend/quotient}.
  // A borrow in div_diff means the trial subtraction is discarded.
  assign div_shift = prod_q[2*DATA_W-1:DATA_W-1];
  assign div_diff  = div_shift - {1'b0, b_mag_q};
  assign div_step  = div_diff[DATA_W]
                   ? {div_shift[DATA_W-1:0], prod_q[DATA_W-2:0], 1'b0}
                   : {div_diff[DATA_W-1:0],  prod_q[DATA_W-2:0], 1'b1};

  // Sign correction. Remainder follows the dividend; the dividend itself is
  // rebuilt from its magnitude for the divide-by-zero HI value.
  assign prod_fix = neg_res_q ? -prod_q : prod_q;
  assign quo_fix  = neg_res_q ? -prod_q[DATA_W-1:0] : prod_q[DATA_W-1:0];
  assign rem_fix  = neg_rem_q ? -prod_q[2*DATA_W-1:DATA_W]
                              : prod_q[2*DATA_W-1:DATA_W];
  assign a_orig   = neg_rem_q ? -a_mag_q : a_mag_q;

  // Next-state logic: accept in IDLE, iterate in CALC, write HI/LO in FIX.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_mag_d     = a_mag_q;
    b_mag_d     = b_mag_q;
    prod_d      = prod_q;
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
    is_div_d    = is_div_q;
    div_zero_d  = div_zero_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    illegal_d   = 1'b0;
    hi_d        = hi_q;
    lo_d        = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_muldiv) begin
            a_mag_d    = a_mag_in;
            b_mag_d    = b_mag_in;
            neg_res_d  = md_signed && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
            neg_rem_d  = md_signed && src_a[DATA_W-1];
            is_div_d   = md_div;
            div_zero_d = md_div && (src_b == '0);
            prod_d     = {{DATA_W{1'b0}}, (md_div ? a_mag_in : b_mag_in)};
            cnt_d      = '0;
            state_d    = ST_CALC;
          end else begin
            result_d    = sc_res;
            illegal_d   = sc_illegal;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_CALC: begin
        prod_d = is_div_q ? div_step : mul_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W-1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[2*DATA_W-1:DATA_W];
          lo_d = prod_fix[DATA_W-1:0];
        end else if (div_zero_q) begin
          hi_d = a_orig;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        result_d    = lo_d;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset aborts any mult/div.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_mag_q     <= '0;
      b_mag_q     <= '0;
      prod_q      <= '0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      is_div_q    <= 1'b0;
      div_zero_q  <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      hi_q        <= HILO_RST;
      lo_q        <= HILO_RST;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_mag_q     <= a_mag_d;
      b_mag_q     <= b_mag_d;
      prod_q      <= prod_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
      is_div_q    <= is_div_d;
      div_zero_q  <= div_zero_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

`ifdef ALU_OVF_TRAP_EN
  logic add_ovf, sub_ovf, sc_ovf, ovf_q, ovf_d;

  assign add_ovf = (src_a[DATA_W-1] == src_b[DATA_W-1]) &&
                   (add_res[DATA_W-1] != src_a[DATA_W-1]);
  assign sub_ovf = (src_a[DATA_W-1] != src_b[DATA_W-1]) &&
                   (sub_res[DATA_W-1] != src_a[DATA_W-1]);

  // Only the add/sub encodings can raise overflow.
  always_comb begin
    sc_ovf = 1'b0;
    if (alu_op == 2'b00 || (alu_op == 2'b10 && funct == F_ADD)) begin
      sc_ovf = add_ovf;
    end else if (alu_op == 2'b01 || (alu_op == 2'b10 && funct == F_SUB)) begin
      sc_ovf = sub_ovf;
    end
  end

  // Overflow flag is registered alongside the single-cycle result.
  always_comb begin
    ovf_d = 1'b0;
    if (state_q == ST_IDLE && in_valid && !is_muldiv) begin
      ovf_d = sc_ovf;
    end
  end

  // Overflow register, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = out_valid_q && (result_q == '0);
  assign illegal   = illegal_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule
